jtframe_mr_ddrld: RTL and testbench

Burst reader that fetches a ROM image from MiSTer DDR memory through the `ddrld_*` request port of the DDR mux, and replays it as a byte stream on the core's programming interface. It issues Avalon-style read bursts and absorbs returned 64-bit words in a local FIFO. The FIFO is needed because returned read data cannot be stalled. It unpacks each word into little-endian bytes with downstream backpressure. It sits between the DDR mux and the SDRAM download logic, active only while `downloading`.

---
 rtl/jtframe_mr_ddrld_pkg.sv | 14 +
 rtl/jtframe_mr_ddrld_fifo.sv | 55 +++++
 rtl/jtframe_mr_ddrld.sv | 175 +++++++++++++++++
 tb/tb_jtframe_mr_ddrld.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_mr_ddrld_pkg.sv
// rtl/jtframe_mr_ddrld_pkg.sv - shared types for the DDR ROM burst loader
package jtframe_mr_ddrld_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RECV,
    ST_WAITSP,
    ST_DRAIN
  } state_t;

  localparam int BYTES_PER_WORD = 8;

endpackage

// File: rtl/jtframe_mr_ddrld_fifo.sv
// rtl/jtframe_mr_ddrld_fifo.sv - 64-bit synchronous FIFO, registered read port
module jtframe_mr_ddrld_fifo #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [63:0]   din,
  input  logic          rd,
  output logic [63:0]   dout,
  output logic          empty,
  output logic [AW:0]   free
);

  localparam int         DEPTH_I = 2 ** AW;
  localparam logic [AW:0] DEPTH  = (AW + 1)'(DEPTH_I);

  logic [63:0]   mem_q [DEPTH_I];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic [63:0]   dout_q;
  logic          do_wr, do_rd;

  assign do_rd = rd && (cnt_q != '0);
  // a full FIFO still takes a write when a pop frees a slot in the same cycle
  assign do_wr = we && ((cnt_q != DEPTH) || do_rd);
  assign empty = (cnt_q == '0);
  assign free  = DEPTH - cnt_q;
  assign dout  = dout_q;

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + AW'(1);
      if (do_rd) begin
        rptr_q <= rptr_q + AW'(1);
        dout_q <= mem_q[rptr_q];
      end
      case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/jtframe_mr_ddrld.sv
// rtl/jtframe_mr_ddrld.sv - DDR burst reader replaying a ROM image as a byte stream
module jtframe_mr_ddrld
  import jtframe_mr_ddrld_pkg::*;
#(
  parameter int BURST   = 16,
  parameter int LENW    = 25,
  parameter int FIFO_AW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [28:0]     base_addr,
  input  logic [LENW-1:0] len,
  output logic            busy,
  output logic            done,
  output logic [7:0]      ddrld_burstcnt,
  output logic [28:0]     ddrld_addr,
  output logic            ddrld_rd,
  input  logic            ddrld_busy,
  input  logic [63:0]     ddr_dout,
  input  logic            ddr_dout_ready,
  output logic [LENW-1:0] prog_addr,
  output logic [7:0]      prog_data,
  output logic            prog_we,
  input  logic            prog_rdy
);

  localparam int WW = LENW - 2;
  localparam int IW = $clog2(BYTES_PER_WORD);
  localparam int SW = FIFO_AW + 2;

  state_t          state_q;
  logic [28:0]     addr_q;
  logic [7:0]      bcnt_q;
  logic            rd_q;
  logic [WW-1:0]   words_left_q;
  logic [7:0]      recv_left_q;
  logic [LENW-1:0] len_q;
  logic            busy_q, done_q;
  logic            have_q;
  logic [IW-1:0]   idx_q;
  logic [LENW-1:0] paddr_q;

  logic            fifo_we, fifo_rd, fifo_empty;
  logic [63:0]     fifo_dout;
  logic [FIFO_AW:0] fifo_free;
  logic [WW-1:0]   n_words;
  logic            space_ok, accept, last_byte, last_in_word;

  function automatic logic [7:0] burst_of(input logic [WW-1:0] words);
    return (words > WW'(BURST)) ? 8'(BURST) : 8'(words);
  endfunction

  assign n_words = WW'(len >> 3) + WW'(len[2:0] != 3'b000);

  // returned words cannot be stalled, so only an active transfer may fill the FIFO
  assign fifo_we  = ddr_dout_ready && (state_q != ST_IDLE);
  assign space_ok = SW'(fifo_free) >= (SW'(BURST) + SW'(fifo_we));

  assign accept       = have_q && prog_rdy;
  assign last_byte    = (paddr_q == len_q - LENW'(1));
  assign last_in_word = (idx_q == IW'(BYTES_PER_WORD - 1)) || last_byte;
  assign fifo_rd      = !fifo_empty && (state_q != ST_IDLE) &&
                        (!have_q || (accept && last_in_word));

  jtframe_mr_ddrld_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (fifo_we),
    .din   (ddr_dout),
    .rd    (fifo_rd),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .free  (fifo_free)
  );

  assign busy           = busy_q;
  assign done           = done_q;
  assign ddrld_burstcnt = bcnt_q;
  assign ddrld_addr     = addr_q;
  assign ddrld_rd       = rd_q;
  assign prog_addr      = paddr_q;
  assign prog_we        = have_q;
  assign prog_data      = have_q ? fifo_dout[{idx_q, 3'b000} +: 8] : 8'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      bcnt_q       <= '0;
      rd_q         <= 1'b0;
      words_left_q <= '0;
      recv_left_q  <= '0;
      len_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      have_q       <= 1'b0;
      idx_q        <= '0;
      paddr_q      <= '0;
    end else begin
      done_q <= 1'b0;

      if (accept) paddr_q <= paddr_q + LENW'(1);
      if (fifo_rd) begin
        have_q <= 1'b1;
        idx_q  <= '0;
      end else if (accept) begin
        if (last_in_word) have_q <= 1'b0;
        else              idx_q  <= idx_q + IW'(1);
      end

      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_q   <= len;
            paddr_q <= '0;
            addr_q  <= base_addr;
            busy_q  <= 1'b1;
            if (len != '0) begin
              state_q      <= ST_REQ;
              rd_q         <= 1'b1;
              words_left_q <= n_words;
              bcnt_q       <= burst_of(n_words);
            end else begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_REQ: begin
          if (!ddrld_busy) begin
            rd_q         <= 1'b0;
            state_q      <= ST_RECV;
            recv_left_q  <= bcnt_q;
            words_left_q <= words_left_q - WW'(bcnt_q);
          end
        end
        ST_RECV: begin
          if (fifo_we) begin
            recv_left_q <= recv_left_q - 8'd1;
            if (recv_left_q == 8'd1) begin
              if (words_left_q == '0) begin
                state_q <= ST_DRAIN;
              end else if (space_ok) begin
                state_q <= ST_REQ;
                rd_q    <= 1'b1;
                addr_q  <= addr_q + 29'(bcnt_q);
                bcnt_q  <= burst_of(words_left_q);
              end else begin
                state_q <= ST_WAITSP;
              end
            end
          end
        end
        ST_WAITSP: begin
          if (space_ok) begin
            state_q <= ST_REQ;
            rd_q    <= 1'b1;
            addr_q  <= addr_q + 29'(bcnt_q);
            bcnt_q  <= burst_of(words_left_q);
          end
        end
        ST_DRAIN: begin
          // the final byte lives in the last word, so it can only be taken here
          if ((len_q == '0) || (accept && last_byte)) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_mr_ddrld.sv
// tb/tb_jtframe_mr_ddrld.sv - scoreboard bench for the DDR ROM burst loader
module tb_jtframe_mr_ddrld;

  localparam int BURST   = 16;
  localparam int LENW    = 25;
  localparam int FIFO_AW = 5;

  typedef struct packed {
    logic [LENW-1:0] addr;
    logic [7:0]      data;
  } byte_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [28:0]     base_addr = '0;
  logic [LENW-1:0] len = '0;
  logic            busy, done;
  logic [7:0]      ddrld_burstcnt;
  logic [28:0]     ddrld_addr;
  logic            ddrld_rd;
  logic            ddrld_busy = 1'b0;
  logic [63:0]     ddr_dout = '0;
  logic            ddr_dout_ready = 1'b0;
  logic [LENW-1:0] prog_addr;
  logic [7:0]      prog_data;
  logic            prog_we;
  logic            prog_rdy = 1'b0;

  jtframe_mr_ddrld #(.BURST(BURST), .LENW(LENW), .FIFO_AW(FIFO_AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .base_addr      (base_addr),
    .len            (len),
    .busy           (busy),
    .done           (done),
    .ddrld_burstcnt (ddrld_burstcnt),
    .ddrld_addr     (ddrld_addr),
    .ddrld_rd       (ddrld_rd),
    .ddrld_busy     (ddrld_busy),
    .ddr_dout       (ddr_dout),
    .ddr_dout_ready (ddr_dout_ready),
    .prog_addr      (prog_addr),
    .prog_data      (prog_data),
    .prog_we        (prog_we),
    .prog_rdy       (prog_rdy)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int err = 0;

  logic [28:0]     pend_q[$];
  byte_t           sb_q[$];
  int              cyc = 0, t0 = 0;
  int              rdy_mode = 0, busy_len = 0, stall_cnt = 0;
  logic [28:0]     cur_base = '0, exp_addr = '0, held_addr = '0;
  logic [LENW-1:0] cur_len = '0;
  logic [7:0]      held_cnt = '0;
  int              words_rem = 0, exp_cnt = 0, accepts = 0, words_ret = 0;
  int              bytes_acc = 0, rd_seen = 0, done_cyc = 0;
  int              first_rdy_cyc = -1, first_we_cyc = -1;
  logic            sb_on = 1'b1, hold_ret = 1'b0;
  logic            done_seen = 1'b0, done_expect = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return (a[7:0] * 8'd29) ^ a[15:8] ^ a[23:16] ^ 8'hA7;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd"}, ddrld_rd, 0);
    chk({tag, "_burstcnt"}, ddrld_burstcnt, 0);
    chk({tag, "_addr"}, ddrld_addr, 0);
    chk({tag, "_prog_we"}, prog_we, 0);
    chk({tag, "_prog_addr"}, prog_addr, 0);
    chk({tag, "_prog_data"}, prog_data, 0);
  endtask

  task automatic step();
    logic [28:0] wa;
    logic [63:0] w;
    int          o;
    byte_t       e;
    @(posedge clk);
    #1;
    cyc++;
    if (done) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
    if (done_expect) begin
      chk("done_pulse", done, 1);
      chk("busy_low_at_done", busy, 0);
      done_expect = 1'b0;
    end
    if (!sb_on) chk("stray_we", prog_we, 0);
    if (ddrld_rd) rd_seen++;

    case (rdy_mode)
      0:       prog_rdy = 1'b1;
      1:       prog_rdy = 1'($urandom_range(0, 1));
      default: prog_rdy = (cyc - t0 >= 2000);
    endcase
    if (rdy_mode == 2 && cyc - t0 == 1999) begin
      chk("rd_withheld", ddrld_rd, 0);
      chk("fifo_bound", words_ret <= (1 << FIFO_AW) + 1, 1);
      chk("fifo_filled", words_ret >= BURST, 1);
    end

    ddr_dout_ready = 1'b0;
    if (!hold_ret && pend_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      wa = pend_q.pop_front();
      for (int k = 0; k < 8; k++) begin
        w[8*k +: 8] = mem_byte({wa, 3'(k)});
        o = int'(wa - cur_base) * 8 + k;
        if (sb_on && o < int'(cur_len)) begin
          e.addr = LENW'(o);
          e.data = mem_byte({wa, 3'(k)});
          sb_q.push_back(e);
        end
      end
      ddr_dout       = w;
      ddr_dout_ready = 1'b1;
      words_ret++;
      if (first_rdy_cyc < 0) first_rdy_cyc = cyc;
    end

    ddrld_busy = 1'b0;
    if (ddrld_rd) begin
      if (stall_cnt == 0) begin
        exp_cnt = (words_rem > BURST) ? BURST : words_rem;
        chk("burst_addr", ddrld_addr, exp_addr);
        chk("burst_cnt", ddrld_burstcnt, exp_cnt);
        held_addr = ddrld_addr;
        held_cnt  = ddrld_burstcnt;
      end else begin
        chk("hold_addr", ddrld_addr, held_addr);
        chk("hold_cnt", ddrld_burstcnt, held_cnt);
      end
      if (stall_cnt < busy_len) begin
        ddrld_busy = 1'b1;
        stall_cnt++;
      end else begin
        for (int i = 0; i < int'(ddrld_burstcnt); i++) pend_q.push_back(ddrld_addr + 29'(i));
        exp_addr  = exp_addr + 29'(exp_cnt);
        words_rem = words_rem - exp_cnt;
        accepts++;
        stall_cnt = 0;
      end
    end

    if (prog_we && first_we_cyc < 0) first_we_cyc = cyc;
    if (prog_we && prog_rdy && sb_on) begin
      if (sb_q.size() == 0) begin
        chk("byte_without_word", 64'(sb_q.size()), 64'(1));
      end else begin
        e = sb_q.pop_front();
        chk("prog_addr", prog_addr, e.addr);
        chk("prog_data", prog_data, e.data);
      end
      bytes_acc++;
      if (bytes_acc == int'(cur_len)) done_expect = 1'b1;
    end
  endtask

  task automatic arm(input logic [28:0] b, input logic [LENW-1:0] l, input int mode, input int bl);
    cur_base = b;   cur_len = l;   exp_addr = b;
    words_rem = (int'(l) + 7) / 8;
    bytes_acc = 0;  accepts = 0;   stall_cnt = 0; words_ret = 0; rd_seen = 0;
    first_rdy_cyc = -1; first_we_cyc = -1;
    done_seen = 1'b0; done_expect = 1'b0;
    rdy_mode = mode; busy_len = bl;
    sb_q.delete();
    sb_on = 1'b1;
    base_addr = b; len = l; start = 1'b1; t0 = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic run_xfer(input logic [28:0] b, input logic [LENW-1:0] l, input int mode, input int bl);
    int start_cyc, exp_bursts, words_tot;
    words_tot  = (int'(l) + 7) / 8;
    exp_bursts = (words_tot + BURST - 1) / BURST;
    start_cyc  = cyc;
    arm(b, l, mode, bl);
    chk("rd_after_start", ddrld_rd, l != '0);
    chk("busy_after_start", busy, 1);
    for (int n = 0; n < 20000 && !done_seen; n++) step();
    chk("done_reached", done_seen, 1);
    if (l == '0) begin
      chk("zero_len_latency", (done_cyc - start_cyc) <= 2, 1);
      chk("zero_len_no_rd", rd_seen, 0);
    end else begin
      chk("bursts", accepts, exp_bursts);
      chk("words_returned", words_ret, words_tot);
      chk("bytes", bytes_acc, l);
      chk("sb_drained", sb_q.size(), 0);
    end
    step();
    chk("done_one_cycle", done, 0);
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    step();
    step();
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    step();

    run_xfer(29'h100, LENW'(16), 0, 0);
    chk("first_we_latency", (first_we_cyc - first_rdy_cyc) <= 2, 1);
    run_xfer(29'h200, LENW'(13), 0, 0);
    run_xfer(29'h40, LENW'(0), 0, 0);
    run_xfer(29'h1000, LENW'(1024), 2, 0);
    run_xfer(29'h3000, LENW'(300), 1, 5);

    arm(29'h2000, LENW'(256), 1, 0);
    for (int n = 0; n < 300 && !(words_ret >= 4 && pend_q.size() >= 3); n++) step();
    chk("reset_window_reached", pend_q.size() >= 3, 1);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("midreset");
    hold_ret = 1'b1;
    sb_on    = 1'b0;
    sb_q.delete();
    while (pend_q.size() > 3) void'(pend_q.pop_back());
    step();
    step();
    rst_n    = 1'b1;
    hold_ret = 1'b0;
    for (int n = 0; n < 40 && pend_q.size() > 0; n++) step();
    chk("late_words_delivered", pend_q.size(), 0);
    step();
    step();
    chk("idle_after_reset_rd", ddrld_rd, 0);
    chk("idle_after_reset_busy", busy, 0);
    sb_on = 1'b1;

    run_xfer(29'h500, LENW'(77), 1, 0);
    run_xfer(29'h1ABC, LENW'(200), 1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
